// File: rtl/ctrl_pkg.sv
// Shared types for the decode control stage: opcode encodings, branch kinds,
// the ID/EX control bundle and its bubble value.
package ctrl_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned CMD_W = 4;
    localparam int unsigned BR_W  = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_CMP  = 4'd5,
        OP_MOVR = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_MOVI = 4'd9,
        OP_LDR  = 4'd10,
        OP_STR  = 4'd11,
        OP_BEQ  = 4'd12,
        OP_JMP  = 4'd13
    } opcode_e;

    localparam logic [BR_W-1:0] BR_BEQ = 4'd12;
    localparam logic [BR_W-1:0] BR_JMP = 4'd13;

    typedef struct packed {
        logic [CMD_W-1:0] exe_cmd;
        logic             branch_en;
        logic [BR_W-1:0]  branch_cmd;
        logic             is_imm;
        logic             is_str;
        logic             is_ldr;
        logic             is_cmp;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Larger of two latencies, used to size the occupancy counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Front-end request and ID/EX control bundle of the decode control stage.
interface decode_ctrl_stage_if #(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned EXE_W = 4
) ();
    logic             in_valid;
    logic [OP_W-1:0]  opcode;
    logic             hazard_detected;
    logic             flush;

    logic             out_valid;
    logic [EXE_W-1:0] exe_cmd;
    logic             branch_en;
    logic [3:0]       branch_cmd;
    logic             is_imm;
    logic             is_str;
    logic             is_ldr;
    logic             is_cmp;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             illegal_op;
    logic             stall_out;

    // Upstream side: issues opcodes, consumes the control bundle.
    modport master (
        output in_valid, opcode, hazard_detected, flush,
        input  out_valid, exe_cmd, branch_en, branch_cmd, is_imm, is_str,
               is_ldr, is_cmp, wb_en, mem_r_en, mem_w_en, illegal_op, stall_out
    );

    // Stage side.
    modport slave (
        input  in_valid, opcode, hazard_detected, flush,
        output out_valid, exe_cmd, branch_en, branch_cmd, is_imm, is_str,
               is_ldr, is_cmp, wb_en, mem_r_en, mem_w_en, illegal_op, stall_out
    );
endinterface

// File: rtl/decode_lut.sv
// Combinational opcode-to-control mapping with illegal and multi-cycle flags.
module decode_lut
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl_c,
    output logic            illegal_c,
    output logic            mul_c,
    output logic            div_c
);

    logic    hi_zero;
    opcode_e op_e;

    // Any set bit above the 4-bit encoding space makes the opcode illegal.
    generate
        if (OP_W > OPC_W) begin : g_wide
            assign hi_zero = ~|opcode[OP_W-1:OPC_W];
        end else begin : g_narrow
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign op_e = opcode_e'(opcode[OPC_W-1:0]);

    // Opcode decode; unnamed signals stay at their bubble value.
    always_comb begin
        ctrl_c    = CTRL_BUBBLE;
        illegal_c = 1'b0;
        mul_c     = 1'b0;
        div_c     = 1'b0;
        if (!hi_zero) begin
            illegal_c = 1'b1;
        end else begin
            case (op_e)
                OP_ADD, OP_SUB, OP_MOVR, OP_AND, OP_OR: begin
                    ctrl_c.exe_cmd = CMD_W'(op_e);
                    ctrl_c.wb_en   = 1'b1;
                end
                OP_MUL: begin
                    ctrl_c.exe_cmd = CMD_W'(op_e);
                    ctrl_c.wb_en   = 1'b1;
                    mul_c          = 1'b1;
                end
                OP_DIV, OP_MOD: begin
                    ctrl_c.exe_cmd = CMD_W'(op_e);
                    ctrl_c.wb_en   = 1'b1;
                    div_c          = 1'b1;
                end
                OP_CMP: begin
                    ctrl_c.exe_cmd = CMD_W'(op_e);
                    ctrl_c.is_cmp  = 1'b1;
                end
                OP_MOVI: begin
                    ctrl_c.wb_en  = 1'b1;
                    ctrl_c.is_imm = 1'b1;
                end
                OP_LDR: begin
                    ctrl_c.exe_cmd  = CMD_W'(OP_ADD);
                    ctrl_c.wb_en    = 1'b1;
                    ctrl_c.mem_r_en = 1'b1;
                    ctrl_c.is_ldr   = 1'b1;
                end
                OP_STR: begin
                    ctrl_c.exe_cmd  = CMD_W'(OP_ADD);
                    ctrl_c.mem_w_en = 1'b1;
                    ctrl_c.is_str   = 1'b1;
                end
                OP_BEQ: begin
                    ctrl_c.exe_cmd    = CMD_W'(op_e);
                    ctrl_c.branch_en  = 1'b1;
                    ctrl_c.branch_cmd = BR_BEQ;
                end
                OP_JMP: begin
                    ctrl_c.exe_cmd    = CMD_W'(op_e);
                    ctrl_c.branch_en  = 1'b1;
                    ctrl_c.branch_cmd = BR_JMP;
                end
                default: illegal_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode control stage: control half of the ID/EX register.
// Build option DECODE_MULTICYCLE_EN: when defined, MUL/DIV/MOD occupy the
// stage for MUL_LAT/DIV_LAT cycles and stall the front end; when undefined,
// every op is single-cycle and stall_out is tied low.
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned EXE_W   = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input logic                clk,
    input logic                rst,
    decode_ctrl_stage_if.slave bus
);

    ctrl_t lut_ctrl;
    logic  lut_illegal;
    logic  lut_mul;
    logic  lut_div;
    logic  accept;

    ctrl_t ctrl_q,    ctrl_d;
    logic  valid_q,   valid_d;
    logic  illegal_q, illegal_d;

    decode_lut #(.OP_W(OP_W)) u_lut (
        .opcode    (bus.opcode),
        .ctrl_c    (lut_ctrl),
        .illegal_c (lut_illegal),
        .mul_c     (lut_mul),
        .div_c     (lut_div)
    );

    assign accept = bus.in_valid && !bus.flush && !bus.hazard_detected;

`ifdef DECODE_MULTICYCLE_EN
    localparam int unsigned CNT_W = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // FSM state and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and bundle; the bundle is held while BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                ctrl_d = CTRL_BUBBLE;
                cnt_d  = '0;
                if (accept) begin
                    if (lut_illegal) begin
                        illegal_d = 1'b1;
                    end else if (lut_mul && (MUL_LAT > 1)) begin
                        ctrl_d       = lut_ctrl;
                        ctrl_d.wb_en = 1'b0;
                        cnt_d        = CNT_W'(MUL_LAT - 1);
                        state_d      = S_BUSY;
                    end else if (lut_div && (DIV_LAT > 1)) begin
                        ctrl_d       = lut_ctrl;
                        ctrl_d.wb_en = 1'b0;
                        cnt_d        = CNT_W'(DIV_LAT - 1);
                        state_d      = S_BUSY;
                    end else begin
                        ctrl_d  = lut_ctrl;
                        valid_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    ctrl_d  = CTRL_BUBBLE;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        ctrl_d.wb_en = 1'b1;
                        valid_d      = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                ctrl_d  = CTRL_BUBBLE;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.stall_out = (state_q == S_BUSY);
`else
    logic unused_cfg;

    // Every op completes in one cycle; latency parameters have no effect.
    always_comb begin
        ctrl_d    = CTRL_BUBBLE;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (accept) begin
            if (lut_illegal) begin
                illegal_d = 1'b1;
            end else begin
                ctrl_d  = lut_ctrl;
                valid_d = 1'b1;
            end
        end
    end

    assign unused_cfg    = lut_mul ^ lut_div ^ (MUL_LAT == 0) ^ (DIV_LAT == 0);
    assign bus.stall_out = 1'b0;
`endif

    // ID/EX control register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.exe_cmd    = EXE_W'(ctrl_q.exe_cmd);
    assign bus.branch_en  = ctrl_q.branch_en;
    assign bus.branch_cmd = ctrl_q.branch_cmd;
    assign bus.is_imm     = ctrl_q.is_imm;
    assign bus.is_str     = ctrl_q.is_str;
    assign bus.is_ldr     = ctrl_q.is_ldr;
    assign bus.is_cmp     = ctrl_q.is_cmp;
    assign bus.wb_en      = ctrl_q.wb_en;
    assign bus.mem_r_en   = ctrl_q.mem_r_en;
    assign bus.mem_w_en   = ctrl_q.mem_w_en;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage with a per-cycle expected-output
// scoreboard; covers both DECODE_MULTICYCLE_EN builds.
module tb_decode_ctrl_stage;

    typedef logic [18:0] exp_t;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MUL = 4'd2,  DIV = 4'd3;
    localparam logic [3:0] MOD = 4'd4,  CMP = 4'd5,  MOVR = 4'd6, AND = 4'd7;
    localparam logic [3:0] OR  = 4'd8,  MOVI = 4'd9, LDR = 4'd10, STR = 4'd11;
    localparam logic [3:0] BEQ = 4'd12, JMP = 4'd13;

    // Qualifier/enable flags: {is_imm, is_str, is_ldr, is_cmp, wb_en, mem_r_en, mem_w_en}
    localparam logic [6:0] F_IMM = 7'b1000000, F_STR = 7'b0100000, F_LDR = 7'b0010000;
    localparam logic [6:0] F_CMP = 7'b0001000, F_WB  = 7'b0000100, F_MR  = 7'b0000010;
    localparam logic [6:0] F_MW  = 7'b0000001;

    logic clk;
    logic rst;

    decode_ctrl_stage_if #(.OP_W(4), .EXE_W(4)) bus ();

    decode_ctrl_stage #(
        .OP_W(4), .EXE_W(4), .MUL_LAT(2), .DIV_LAT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic exp_t ex(input logic ov, input logic [3:0] cmd, input logic br,
                                input logic [3:0] brc, input logic [6:0] fl,
                                input logic ill, input logic st);
        return {ov, cmd, br, brc, fl, ill, st};
    endfunction

    localparam exp_t NONE = 19'd0;

    // Monitor: every cycle with a pending expectation is compared.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  act;
        string n;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = {bus.out_valid, bus.exe_cmd, bus.branch_en, bus.branch_cmd,
                   bus.is_imm, bus.is_str, bus.is_ldr, bus.is_cmp, bus.wb_en,
                   bus.mem_r_en, bus.mem_w_en, bus.illegal_op, bus.stall_out};
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (ov cmd br brc imm str ldr cmp wb mr mw ill stall)",
                         n, act, e);
            end
        end
    end

    // Apply inputs across one rising edge, then queue the outputs expected after it.
    task automatic step(input string n, input logic r, input logic v, input logic [3:0] op,
                        input logic hz, input logic fl, input exp_t e);
        rst                 = r;
        bus.in_valid        = v;
        bus.opcode          = op;
        bus.hazard_detected = hz;
        bus.flush           = fl;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.opcode          = 4'd0;
        bus.hazard_detected = 1'b0;
        bus.flush           = 1'b0;

        step("rst0", 1, 0, ADD, 0, 0, NONE);
        step("rst1", 1, 1, ADD, 0, 0, NONE);

        step("add",  0, 1, ADD,  0, 0, ex(1, 4'd0,  0, 4'd0,  F_WB, 0, 0));
        step("ldr",  0, 1, LDR,  0, 0, ex(1, 4'd0,  0, 4'd0,  F_WB | F_MR | F_LDR, 0, 0));
        step("str",  0, 1, STR,  0, 0, ex(1, 4'd0,  0, 4'd0,  F_MW | F_STR, 0, 0));
        step("cmp",  0, 1, CMP,  0, 0, ex(1, 4'd5,  0, 4'd0,  F_CMP, 0, 0));
        step("movi", 0, 1, MOVI, 0, 0, ex(1, 4'd0,  0, 4'd0,  F_IMM | F_WB, 0, 0));
        step("beq",  0, 1, BEQ,  0, 0, ex(1, 4'd12, 1, 4'd12, 7'd0, 0, 0));
        step("jmp",  0, 1, JMP,  0, 0, ex(1, 4'd13, 1, 4'd13, 7'd0, 0, 0));
        step("sub",  0, 1, SUB,  0, 0, ex(1, 4'd1,  0, 4'd0,  F_WB, 0, 0));
        step("movr", 0, 1, MOVR, 0, 0, ex(1, 4'd6,  0, 4'd0,  F_WB, 0, 0));
        step("and",  0, 1, AND,  0, 0, ex(1, 4'd7,  0, 4'd0,  F_WB, 0, 0));
        step("or",   0, 1, OR,   0, 0, ex(1, 4'd8,  0, 4'd0,  F_WB, 0, 0));

        step("noval",     0, 0, ADD,   0, 0, NONE);
        step("hazard",    0, 1, ADD,   1, 0, NONE);
        step("hz_flush",  0, 1, ADD,   1, 1, NONE);
        step("ill15",     0, 1, 4'd15, 0, 0, ex(0, 4'd0, 0, 4'd0, 7'd0, 1, 0));
        step("ill14_inv", 0, 0, 4'd14, 0, 0, NONE);
        step("ill14_hz",  0, 1, 4'd14, 1, 0, NONE);
        step("ill14",     0, 1, 4'd14, 0, 0, ex(0, 4'd0, 0, 4'd0, 7'd0, 1, 0));
        step("add_after", 0, 1, ADD,   0, 0, ex(1, 4'd0, 0, 4'd0, F_WB, 0, 0));

`ifdef DECODE_MULTICYCLE_EN
        // MUL, LAT=2: one stalled cycle, then commit; input during BUSY is ignored.
        step("mul_busy", 0, 1, MUL, 0, 0, ex(0, 4'd2, 0, 4'd0, 7'd0, 0, 1));
        step("mul_done", 0, 1, ADD, 1, 0, ex(1, 4'd2, 0, 4'd0, F_WB, 0, 0));
        step("mul_next", 0, 1, ADD, 0, 0, ex(1, 4'd0, 0, 4'd0, F_WB, 0, 0));

        // Flush in the completing BUSY cycle kills the MUL.
        step("mulf_busy",  0, 1, MUL, 0, 0, ex(0, 4'd2, 0, 4'd0, 7'd0, 0, 1));
        step("mulf_flush", 0, 1, ADD, 1, 1, NONE);
        step("mulf_idle",  0, 0, ADD, 0, 0, NONE);

        // DIV, LAT=8: seven stalled cycles, one commit, then the held SUB.
        step("div_busy", 0, 1, DIV, 0, 0, ex(0, 4'd3, 0, 4'd0, 7'd0, 0, 1));
        for (int i = 0; i < 6; i++)
            step("div_hold", 0, 1, SUB, 1'(i % 2), 0, ex(0, 4'd3, 0, 4'd0, 7'd0, 0, 1));
        step("div_done", 0, 1, SUB, 0, 0, ex(1, 4'd3, 0, 4'd0, F_WB, 0, 0));
        step("div_next", 0, 1, SUB, 0, 0, ex(1, 4'd1, 0, 4'd0, F_WB, 0, 0));

        // Reset while BUSY returns to the reset state.
        step("mod_busy",  0, 1, MOD, 0, 0, ex(0, 4'd4, 0, 4'd0, 7'd0, 0, 1));
        step("mod_hold",  0, 1, ADD, 0, 0, ex(0, 4'd4, 0, 4'd0, 7'd0, 0, 1));
        step("mod_rst",   1, 1, ADD, 0, 0, NONE);
        step("mod_after", 0, 1, ADD, 0, 0, ex(1, 4'd0, 0, 4'd0, F_WB, 0, 0));
`else
        step("mul_single", 0, 1, MUL, 0, 0, ex(1, 4'd2, 0, 4'd0, F_WB, 0, 0));
        step("div_single", 0, 1, DIV, 0, 0, ex(1, 4'd3, 0, 4'd0, F_WB, 0, 0));
        step("mod_single", 0, 1, MOD, 0, 0, ex(1, 4'd4, 0, 4'd0, F_WB, 0, 0));
        step("mod_next",   0, 1, ADD, 0, 0, ex(1, 4'd0, 0, 4'd0, F_WB, 0, 0));
`endif

        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, parametrised successor to the combinational decode controller. Decodes the opcode into the ID/EX control bundle one cycle later, inserts bubbles on hazard or flush, and sequences multi-cycle MUL/DIV/MOD by holding the front end until the op completes. Sits between the IF/ID register and the EX stage; the outputs form the control half of the ID/EX register.

## Interface
Parameters:
- OP_W, 4: opcode width; must be at least 4.
- EXE_W, 4: exe_cmd width.
- MUL_LAT, 2: cycles MUL occupies the stage; must be at least 1.
- DIV_LAT, 8: cycles DIV and MOD occupy the stage; must be at least 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  opcode is a real instruction; 0 means bubble.
- opcode  in  OP_W  instruction opcode.
- hazard_detected  in  1  insert a bubble this cycle.
- flush  in  1  branch taken; kill the in-flight op.
- out_valid  out  1  the registered op commits this cycle.
- exe_cmd  out  EXE_W  ALU command.
- branch_en  out  1  branch instruction.
- branch_cmd  out  4  branch kind: BEQ or JMP.
- is_imm, is_str, is_ldr, is_cmp  out  1 each  operand and compare qualifiers.
- wb_en, mem_r_en, mem_w_en  out  1 each  write enables.
- illegal_op  out  1  an unsupported opcode was accepted.
- stall_out  out  1  hold the IF/ID register and PC.

## Operation
- Opcode encoding:
  - ADD 0, SUB 1, MUL 2, DIV 3, MOD 4, CMP 5, MOVR 6, AND 7, OR 8, MOVI 9, LDR 10, STR 11, BEQ 12, JMP 13.
  - All other codes are illegal.
- Decode:
  - ALU ops (ADD, SUB, MUL, DIV, MOD, MOVR, AND, OR): exe_cmd = op, wb_en = 1.
  - CMP: exe_cmd = CMP, is_cmp = 1, wb_en = 0.
  - MOVI: wb_en = 1, is_imm = 1.
  - LDR: exe_cmd = ADD, wb_en = 1, mem_r_en = 1, is_ldr = 1.
  - STR: exe_cmd = ADD, mem_w_en = 1, is_str = 1.
  - BEQ and JMP: branch_en = 1, branch_cmd = op, exe_cmd = op, wb_en = 0.
  - Every signal not named for an opcode is 0.
- Bubble: all control outputs and out_valid are 0.
- Accept priority each edge in state IDLE, highest first: rst, flush, hazard_detected, !in_valid, decode.
  - flush, hazard_detected and !in_valid each load a bubble.
  - Otherwise the decoded bundle is loaded.
- Illegal opcode: loads a bubble and pulses illegal_op = 1 for one cycle.
- FSM has two states, IDLE and BUSY, with counter cnt.
  - Accepting MUL (or DIV/MOD) with LAT > 1, where LAT is MUL_LAT or DIV_LAT respectively: load the bundle with wb_en forced 0, out_valid = 0, cnt = LAT-1, go to BUSY.
  - In BUSY: opcode, in_valid and hazard_detected are ignored; the bundle is held; cnt decrements each edge.
  - On the edge where cnt goes 1 to 0: wb_en = 1, out_valid = 1, return to IDLE.
  - LAT = 1 behaves exactly like a single-cycle op.
- stall_out = (state == BUSY), combinational from state; 0 in IDLE.
- flush in BUSY: loads a bubble, sets cnt = 0, returns to IDLE. flush wins over a simultaneous hazard_detected and over a simultaneous completion.
- cnt width: $clog2(max(MUL_LAT, DIV_LAT) + 1).

## Timing
- Reset: every output is 0, state = IDLE, cnt = 0, stall_out = 0.
- Single-cycle op accepted at edge N: bundle with out_valid = 1 is visible from N to N+1.
- Multi-cycle op accepted at edge N:
  - Bundle is visible for LAT cycles.
  - out_valid and wb_en are high only in the last of those cycles.
  - stall_out is high for LAT-1 cycles starting after edge N.
  - The next instruction is accepted at edge N+LAT.
- rst asserted in BUSY: returns to the reset state at that edge.

## Configuration
- DECODE_MULTICYCLE_EN defined: MUL/DIV/MOD sequencing is as described above.
- Undefined:
  - All ops are single-cycle and the FSM and counter are removed.
  - stall_out is tied to 0.
  - MUL_LAT and DIV_LAT are ignored.

## Structure
- Package ctrl_pkg holds:
  - the opcode enum with the encodings above;
  - BR_BEQ and BR_JMP constants;
  - the ctrl_t struct (exe_cmd, branch_en, branch_cmd, the qualifiers, the enables);
  - the CTRL_BUBBLE constant.
- Sub-module decode_lut: purely combinational opcode-to-ctrl_t mapping plus illegal and multi-cycle flags. The top level holds the register, the FSM and the counter.

## Test plan
- Reset, then ADD with in_valid = 1: one cycle later exe_cmd = 0, wb_en = 1, out_valid = 1, all other outputs 0.
- LDR, then STR: LDR gives wb_en = mem_r_en = is_ldr = 1. STR gives mem_w_en = is_str = 1 and wb_en = 0.
- DIV with DIV_LAT = 8, macro defined:
  - stall_out = 1 for 7 cycles, wb_en = 0 for 7 cycles, then one cycle with wb_en = out_valid = 1.
  - The held next opcode is accepted at edge N+8.
- MUL with MUL_LAT = 2, flush asserted in the BUSY cycle: next cycle is a bubble with stall_out = 0 and no wb_en ever.
- ADD with hazard_detected and flush together, then opcode 15: a bubble, then a bubble with illegal_op = 1 for exactly one cycle.
- Macro undefined, MOD: single cycle with wb_en = out_valid = 1 and stall_out never asserted.
